// File: rtl/controle_varredura_esr_if.sv
// Signal bundle between the sensor-SR error scan controller and its
// neighbours (fault source, operator panel, 7-segment decoder).
//   erro_sr        : raw sensor-SR fault level (async to the clock)
//   limpar         : operator acknowledge, debounced, clock-synchronous
//   saida1Contador : digit-select MSB to the decoder
//   saida2Contador : digit-select LSB to the decoder
//   digito         : active-low digit enables, digito[0] = leftmost digit
//   erro_ativo     : high while the fault is latched
// The controller connects through the slave modport; whatever drives the
// fault/acknowledge inputs and watches the display uses the master modport.
interface controle_varredura_esr_if;
    logic       erro_sr;
    logic       limpar;
    logic       saida1Contador;
    logic       saida2Contador;
    logic [3:0] digito;
    logic       erro_ativo;

    modport master (
        output erro_sr,
        output limpar,
        input  saida1Contador,
        input  saida2Contador,
        input  digito,
        input  erro_ativo
    );

    modport slave (
        input  erro_sr,
        input  limpar,
        output saida1Contador,
        output saida2Contador,
        output digito,
        output erro_ativo
    );
endinterface

// File: rtl/controle_varredura_esr.sv
// Sensor-SR error scan controller.
// Latches the (synchronized) sensor-SR fault and, while it is latched, scans
// the 2-bit digit-select code 0,1,2,3 across a four-digit display with a
// dwell of PRESCALE clocks per digit. A blink gate blanks the whole display
// for BLINK_TICKS scan ticks out of every 2*BLINK_TICKS. The fault clears
// only when the operator acknowledges (limpar) after the sensor recovered.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high; returns the block to IDLE
//   bus   : slave side of controle_varredura_esr_if (see interface header)
// Every output is a register or a pure decode of registers.
module controle_varredura_esr #(
    parameter int PRESCALE    = 50000,  // clocks per scan tick, >= 2
    parameter int BLINK_TICKS = 250     // scan ticks per blink half-period, >= 1
) (
    input  logic                         clock,
    input  logic                         reset,
    controle_varredura_esr_if.slave      bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ALERTA = 1'b1
    } state_t;

    localparam int PW = $clog2(PRESCALE);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    logic          sync1;
    logic          erro_s;
    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [1:0]    scan;
    logic [BW-1:0] blink;
    logic          visivel;
    logic          tick;
    logic          stay_alerta;

    // Two-flop synchronizer for the asynchronous fault level.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, which is what makes this a 2-stage chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 1'b0;
            erro_s <= 1'b0;
        end else begin
            sync1  <= bus.erro_sr;
            erro_s <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch on a synchronized fault; release only on acknowledge with the
    // sensor already recovered (a still-active fault ignores limpar).
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // (which would infer a latch).
        state_next = state;
        case (state)
            IDLE: begin
                if (erro_s) begin
                    state_next = ALERTA;
                end
            end
            ALERTA: begin
                if (bus.limpar && !erro_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tick = (state == ALERTA) && (presc == PRESC_MAX);

    // Counters run only while ALERTA is held across the edge; entering or
    // leaving ALERTA (or sitting in IDLE) starts them fresh with the display
    // visible.
    assign stay_alerta = (state == ALERTA) && (state_next == ALERTA);

    always_ff @(posedge clock) begin
        if (reset || !stay_alerta) begin
            presc   <= '0;
            scan    <= 2'd0;
            blink   <= '0;
            visivel <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                scan <= scan + 2'd1;
                if (blink == BLINK_MAX) begin
                    blink   <= '0;
                    visivel <= ~visivel;
                end else begin
                    blink <= blink + 1'b1;
                end
            end
        end
    end

    assign bus.erro_ativo     = (state == ALERTA);
    assign bus.saida1Contador = scan[1];
    assign bus.saida2Contador = scan[0];
    assign bus.digito         = ((state == ALERTA) && visivel) ? ~(4'b0001 << scan)
                                                               : 4'b1111;

endmodule

// File: tb/tb_controle_varredura_esr.sv
// Self-checking bench for controle_varredura_esr with PRESCALE=4,
// BLINK_TICKS=2. A reference model, written in terms of "cycles spent in the
// alert state", predicts every post-edge output and queues it; a monitor on
// the falling edge pops each prediction and compares it with the DUT.
module tb_controle_varredura_esr;

    localparam int P = 4;
    localparam int B = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    controle_varredura_esr_if bus ();

    controle_varredura_esr #(
        .PRESCALE    (P),
        .BLINK_TICKS (B)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ativo;
        logic [1:0] sel;
        logic [3:0] dig;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state.
    bit m_alerta    = 1'b0;
    int m_t         = 0;     // cycles spent in ALERTA since entry
    bit sr_1ago     = 1'b0;  // erro_sr sampled one edge ago
    bit sr_2ago     = 1'b0;  // erro_sr sampled two edges ago (= erro_s now)

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance the model by one edge with the inputs the DUT sampled there.
    task automatic model_edge(input bit rst, input bit sr, input bit lim);
        exp_t e;
        int   ticks;
        if (rst) begin
            m_alerta = 1'b0;
            m_t      = 0;
            sr_1ago  = 1'b0;
            sr_2ago  = 1'b0;
        end else begin
            if (!m_alerta && sr_2ago) begin
                m_alerta = 1'b1;
                m_t      = 0;
            end else if (m_alerta && lim && !sr_2ago) begin
                m_alerta = 1'b0;
                m_t      = 0;
            end else if (m_alerta) begin
                m_t++;
            end
            sr_2ago = sr_1ago;
            sr_1ago = sr;
        end
        e.ativo = m_alerta;
        e.sel   = 2'd0;
        e.dig   = 4'b1111;
        if (m_alerta) begin
            ticks = m_t / P;
            e.sel = 2'(ticks % 4);
            if (((ticks / B) % 2) == 0) begin
                e.dig = ~(4'b0001 << e.sel);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit rst, input bit sr, input bit lim);
        reset      = rst;
        bus.erro_sr = sr;
        bus.limpar = lim;
        @(posedge clock);
        model_edge(rst, sr, lim);
        #1;
    endtask

    task automatic cycles(input int n, input bit rst, input bit sr, input bit lim);
        for (int i = 0; i < n; i++) cycle(rst, sr, lim);
    endtask

    // Monitor: one prediction per edge, compared mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("erro_ativo", 32'(bus.erro_ativo), 32'(e.ativo));
            check("select", 32'({bus.saida1Contador, bus.saida2Contador}), 32'(e.sel));
            check("digito", 32'(bus.digito), 32'(e.dig));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sr;
        bit lim;
        bit rst;
        bus.erro_sr = 1'b0;
        bus.limpar  = 1'b0;

        // Reset state.
        cycles(2, 1'b1, 1'b0, 1'b0);

        // Fault latches 3 edges after first sample; full scan plus blink.
        cycles(40, 1'b0, 1'b1, 1'b0);

        // Acknowledge while fault still active is ignored.
        cycles(10, 1'b0, 1'b1, 1'b1);

        // Sensor recovers, then a one-cycle acknowledge clears.
        cycles(3, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycles(6, 1'b0, 1'b0, 1'b0);

        // Acknowledge in IDLE has no effect.
        cycles(3, 1'b0, 1'b0, 1'b1);

        // Re-latch, reset pulsed mid-scan (select = 2) with fault held.
        cycles(3 + 2 * P + 1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycles(12, 1'b0, 1'b1, 1'b0);

        // Clear, then a one-cycle glitch is still latched (sticky).
        cycles(3, 1'b0, 1'b0, 1'b1);
        cycles(4, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycles(20, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycles(4, 1'b0, 1'b0, 1'b0);

        // Acknowledge on the very edge the fault returns: IDLE first, then
        // fresh re-entry.
        cycles(6, 1'b0, 1'b1, 1'b0);
        cycles(2, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycles(8, 1'b0, 1'b1, 1'b0);

        // Randomized phase.
        sr = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) sr = ~sr;
            lim = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle(rst, sr, lim);
        end

        cycles(3, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
